rv32_m_ext_unit: RTL and testbench
==================================

Name: rv32_m_ext_unit

Overview:
- External RV32M multiply/divide responder. It sits outside the core and is the other end of the ex stage's external-M handshake.
- Accepts a one-cycle start pulse carrying rs1, rs2 and funct3, computes iteratively, then returns the result with a one-cycle acknowledge.
- Holds no architectural state; the core stalls until the acknowledge arrives.

Parameters:
- XLEN, default 32: operand and result width. Only 32 is supported.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; asynchronous, active-high.
- i_en  in  1  start pulse; operands are sampled on the rising edge where i_en=1 and the unit is IDLE.
- i_rs1  in  XLEN  operand A (multiplicand / dividend).
- i_rs2  in  XLEN  operand B (multiplier / divisor).
- i_f3  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- o_res  out  XLEN  result; valid in the o_ack cycle and held until the next accepted start.
- o_ack  out  1  completion pulse, exactly one cycle wide.
- o_busy  out  1  high from the cycle after an accepted start through the o_ack cycle.

Behaviour:
- Reset (any time, including mid-operation): state=IDLE, o_res=0, o_ack=0, o_busy=0, all internal registers cleared. No ack is issued for an aborted operation.
- FSM states: IDLE, PREP, CALC, DONE.
- IDLE -> PREP on i_en.
  - Latch i_f3.
  - Latch magnitudes |rs1| and |rs2| using the signedness rules below.
  - Latch the result-sign flags.
- Signedness per op:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- PREP -> DONE, division special cases (early exit):
  - Divisor zero:
    - DIV, DIVU -> all ones (32'hFFFF_FFFF).
    - REM, REMU -> dividend, unmodified.
  - Signed overflow (DIV/REM with rs1=32'h8000_0000, rs2=32'hFFFF_FFFF):
    - DIV -> 32'h8000_0000.
    - REM -> 0.
- PREP -> CALC otherwise; the iteration counter is loaded with XLEN-1.
- CALC, multiply: one shift-add step per cycle into a 2*XLEN accumulator.
- CALC, divide: one restoring-division step per cycle (shift remainder, trial subtract, set quotient bit).
- CALC exit: when the counter reaches 0, go to DONE.
- DONE:
  - Apply two's-complement sign correction.
  - Multiply sign = sign(A) XOR sign(B).
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(dividend).
  - Select the result: MUL -> low XLEN bits; MULH/MULHSU/MULHU -> high XLEN bits; quotient or remainder for the divide ops.
  - Register o_res; o_ack=1 for this cycle only; return to IDLE.
- Latency, counting the start edge as edge 0 with o_ack high in cycle N:
  - Normal op: N = XLEN+2 = 34.
  - Early-exit divide: N = 2.
- i_en while not IDLE: ignored entirely. Operands are not relatched and no second ack is produced.
- i_en in the o_ack cycle: not accepted; the unit is still in DONE. The requester must re-pulse.
- o_busy=1 in PREP, CALC and DONE.
- Operands are internal copies; changes on i_rs1/i_rs2/i_f3 after the start edge have no effect.

Optional Feature:
- Macro: RV32M_FAST_MUL_EN.
- Defined:
  - f3=0..3 use a combinational 33x33 signed multiplier.
  - IDLE -> DONE directly; o_ack comes in cycle 1 (latency 1) with the correct product.
  - Divide ops are unchanged (iterative).
- Undefined: all ops use the iterative path described above; no hardware multiplier is inferred.

Test Plan:
- MUL rs1=7, rs2=-3 (32'hFFFF_FFFD) -> o_ack once at cycle 34 (cycle 1 with RV32M_FAST_MUL_EN), o_res=32'hFFFF_FFEB; o_res still 32'hFFFF_FFEB 5 cycles later.
- MULH 32'h8000_0000 x 32'h8000_0000 -> o_res=32'h4000_0000. MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFE. MULHSU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFF.
- DIV -20/6 -> 32'hFFFF_FFFD (-3); REM -20/6 -> 32'hFFFF_FFFE (-2); DIVU 20/6 -> 3; REMU 20/6 -> 2; each acked at cycle 34.
- Divide by zero: DIV 5/0 -> 32'hFFFF_FFFF with ack at cycle 2; REMU 5/0 -> 5. Overflow DIV 32'h8000_0000/-1 -> 32'h8000_0000; REM of the same operands -> 0; both acked at cycle 2.
- Extra i_en pulses at cycles 5 and 20 with different operands during a DIVU 100/7 -> single ack at cycle 34 with o_res=14; no further ack follows.
- Assert i_rst at cycle 10 of a MUL -> o_busy/o_ack/o_res go to 0 immediately; no ack ever arrives. A new DIVU 9/2 started after release -> o_res=4 at cycle 34.

Source files
------------

// File: rtl/rv32_m_ext_unit.sv
// -----------------------------------------------------------------------------
// rv32_m_ext_unit
//
// External RV32M multiply/divide responder. The core's ex stage raises a
// one-cycle start pulse with rs1, rs2 and funct3, then stalls until this unit
// returns the result together with a one-cycle acknowledge. No architectural
// state is kept here.
//
// Operation: operand magnitudes and result-sign flags are captured on the
// start edge. Multiplies run an unsigned shift-add over the magnitudes and
// divides run a restoring divider, one bit per cycle, both sharing a single
// 2*XLEN accumulator. Two's-complement sign correction is applied to the final
// step's value. Division by zero and the signed-overflow case bypass the
// iteration.
//
// Latency, counting the accepting edge as edge 0:
//   normal op         : o_ack high in cycle XLEN+2 (34)
//   early-exit divide : o_ack high in cycle 2
//
// Optional feature (macro RV32M_FAST_MUL_EN):
//   defined   - funct3 0..3 use a combinational 33x33 signed multiplier and
//               acknowledge in cycle 1; divides stay iterative.
//   undefined - every op uses the iterative path; no multiplier is inferred.
//
// Ports:
//   i_clk   in   1     clock
//   i_rst   in   1     asynchronous active-high reset
//   i_en    in   1     start pulse, accepted only while IDLE
//   i_rs1   in   XLEN  operand A (multiplicand / dividend)
//   i_rs2   in   XLEN  operand B (multiplier / divisor)
//   i_f3    in   3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                      4 DIV, 5 DIVU, 6 REM, 7 REMU
//   o_res   out  XLEN  result; valid with o_ack and held until the next start
//   o_ack   out  1     one-cycle completion pulse
//   o_busy  out  1     high from the cycle after a start through the ack cycle
// -----------------------------------------------------------------------------
module rv32_m_ext_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_f3,
    output logic [XLEN-1:0] o_res,
    output logic            o_ack,
    output logic            o_busy
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN-1);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        DONE
    } state_t;

    state_t              state_reg;
    logic [2:0]          f3_reg;
    logic [XLEN-1:0]     a_mag_reg;
    logic [XLEN-1:0]     b_mag_reg;
    logic                neg_a_reg;
    logic                neg_b_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic [CW-1:0]       cnt_reg;

    // ---------------------------------------------------------------------
    // Operand signedness and magnitudes for the incoming request
    // ---------------------------------------------------------------------
    logic            sgn_a_in;
    logic            sgn_b_in;
    logic            neg_a_in;
    logic            neg_b_in;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;

    always_comb begin
        sgn_a_in = 1'b0;
        sgn_b_in = 1'b0;
        case (i_f3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sgn_a_in = 1'b1;
                sgn_b_in = 1'b1;
            end
            3'd2:    sgn_a_in = 1'b1;   // MULHSU: only rs1 is signed
            default: ;
        endcase
    end

    assign neg_a_in = sgn_a_in & i_rs1[XLEN-1];
    assign neg_b_in = sgn_b_in & i_rs2[XLEN-1];
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign a_mag_in = neg_a_in ? -i_rs1 : i_rs1;
    assign b_mag_in = neg_b_in ? -i_rs2 : i_rs2;

    // ---------------------------------------------------------------------
    // One iteration step of each algorithm
    // ---------------------------------------------------------------------
    logic              is_div;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] fin_acc;

    assign is_div = f3_reg[2];

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Conditionally add the multiplicand to the high half, then shift right.
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
                    + (acc_reg[0] ? {1'b0, a_mag_reg} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}.
    // Shift the next dividend bit into the remainder and trial-subtract.
    // div_shift is below 2*divisor, so bit XLEN of the difference is a
    // clean borrow flag.
    assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, b_mag_reg};
    assign div_ge    = ~div_diff[XLEN];
    assign div_step  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0],
                        acc_reg[XLEN-2:0], div_ge};

    assign fin_acc = is_div ? div_step : mul_step;

    // ---------------------------------------------------------------------
    // Sign correction and result selection. This is formed from the last
    // step's value so the result lands in o_res as the FSM enters DONE,
    // making the DONE cycle the acknowledge cycle.
    // ---------------------------------------------------------------------
    logic              res_neg;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_calc;

    assign res_neg  = neg_a_reg ^ neg_b_reg;
    assign prod_fix = res_neg ? -fin_acc : fin_acc;
    assign quo_fix  = res_neg ? -fin_acc[XLEN-1:0] : fin_acc[XLEN-1:0];
    assign rem_fix  = neg_a_reg ? -fin_acc[2*XLEN-1:XLEN] : fin_acc[2*XLEN-1:XLEN];

    always_comb begin
        res_calc = prod_fix[XLEN-1:0];
        case (f3_reg)
            3'd0:             res_calc = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: res_calc = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       res_calc = quo_fix;
            default:          res_calc = rem_fix;
        endcase
    end

    // ---------------------------------------------------------------------
    // Division special cases resolved straight from the latched operands
    // ---------------------------------------------------------------------
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] res_early;

    assign div_zero = (b_mag_reg == '0);
    // Negative flags only exist for signed ops, so this matches exactly
    // rs1 = most-negative, rs2 = -1 for DIV/REM.
    assign div_ovf  = neg_a_reg & neg_b_reg & (a_mag_reg == MIN_NEG) & (b_mag_reg == ONE);
    assign dividend = neg_a_reg ? -a_mag_reg : a_mag_reg;

    always_comb begin
        if (div_zero) begin
            res_early = f3_reg[1] ? dividend : {XLEN{1'b1}};
        end else begin
            res_early = f3_reg[1] ? {XLEN{1'b0}} : MIN_NEG;
        end
    end

`ifdef RV32M_FAST_MUL_EN
    // Single-cycle product: sign-extend each operand by one bit according to
    // its signedness so one signed multiplier covers all four multiply ops.
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
    logic        [XLEN-1:0]   fast_res;

    assign fast_a    = {sgn_a_in & i_rs1[XLEN-1], i_rs1};
    assign fast_b    = {sgn_b_in & i_rs2[XLEN-1], i_rs2};
    assign fast_prod = (2*XLEN+2)'(fast_a) * (2*XLEN+2)'(fast_b);
    assign fast_res  = (i_f3[1:0] == 2'd0) ? fast_prod[XLEN-1:0]
                                           : fast_prod[2*XLEN-1:XLEN];
`endif

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            f3_reg    <= '0;
            a_mag_reg <= '0;
            b_mag_reg <= '0;
            neg_a_reg <= 1'b0;
            neg_b_reg <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            o_res     <= '0;
            o_ack     <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    o_ack  <= 1'b0;
                    o_busy <= 1'b0;
                    if (i_en) begin
                        f3_reg    <= i_f3;
                        a_mag_reg <= a_mag_in;
                        b_mag_reg <= b_mag_in;
                        neg_a_reg <= neg_a_in;
                        neg_b_reg <= neg_b_in;
                        o_busy    <= 1'b1;
`ifdef RV32M_FAST_MUL_EN
                        if (!i_f3[2]) begin
                            o_res     <= fast_res;
                            o_ack     <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= PREP;
                        end
`else
                        state_reg <= PREP;
`endif
                    end
                end
                PREP: begin
                    if (is_div && (div_zero || div_ovf)) begin
                        o_res     <= res_early;
                        o_ack     <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        // Multiply walks the multiplier, divide walks the dividend.
                        acc_reg   <= {{XLEN{1'b0}}, (is_div ? a_mag_reg : b_mag_reg)};
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= fin_acc;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        o_res     <= res_calc;
                        o_ack     <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Acknowledge cycle; a start seen here is deliberately dropped.
                    o_ack     <= 1'b0;
                    o_busy    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_m_ext_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rv32_m_ext_unit.
// A reference model computes each result with 64-bit integer arithmetic and
// the expected acknowledge cycle from the op and operands. A negedge monitor
// compares o_ack / o_busy / o_res against that model on every cycle.
// -----------------------------------------------------------------------------
module tb_rv32_m_ext_unit;

    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [31:0] res;
    logic        ack;
    logic        busy;

    always #5 clk = ~clk;

    rv32_m_ext_unit #(.XLEN(32)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_rs1  (rs1),
        .i_rs2  (rs2),
        .i_f3   (f3),
        .o_res  (res),
        .o_ack  (ack),
        .o_busy (busy)
    );

    int          checks   = 0;
    int          errors   = 0;
    bit          pending  = 1'b0;
    int          cyc      = 0;
    int          exp_lat  = 0;
    logic [31:0] exp_res  = '0;
    logic [31:0] hold_res = '0;
    string       cur_name = "reset";

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            3'd0, 3'd1: p = 64'(sa * sb);
            3'd2:       p = 64'(sa * ub);
            3'd3:       p = 64'(ua * ub);
            3'd4:       p = (b == 0) ? '1 : 64'(sa / sb);
            3'd5:       p = (b == 0) ? '1 : 64'(ua / ub);
            3'd6:       p = (b == 0) ? 64'(ua) : 64'(sa % sb);
            default:    p = (b == 0) ? 64'(ua) : 64'(ua % ub);
        endcase
        if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[63:32];
        return p[31:0];
    endfunction

    function automatic int lat_m(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef RV32M_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        if (f[2]) begin
            if (b == 0) return 2;
            if (!f[0] && a == MIN && b == 32'hFFFF_FFFF) return 2;
        end
        return 34;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s [%s] t=%0t: got %h expected %h", nm, cur_name, $time, act, expv);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (pending) begin
            cyc++;
            chk("busy", {31'b0, busy}, 32'd1);
            if (cyc >= exp_lat) begin
                chk("ack", {31'b0, ack}, 32'd1);
                chk("res", res, exp_res);
                hold_res = exp_res;
                pending  = 1'b0;
                $display("op %s done: res=%h cycle=%0d", cur_name, res, cyc);
            end else begin
                chk("ack_early", {31'b0, ack}, 32'd0);
            end
        end else begin
            chk("idle_ack", {31'b0, ack}, 32'd0);
            chk("idle_busy", {31'b0, busy}, 32'd0);
            chk("held_res", res, hold_res);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] e, input int l);
        @(posedge clk); #1;
        en = 1'b1; f3 = f; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        en  = 1'b0;
        rs1 = $urandom; rs2 = $urandom; f3 = 3'($urandom);
        cur_name = nm; exp_res = e; exp_lat = l; cyc = 0; pending = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (pending && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (pending) begin
            checks++;
            errors++;
            $display("FAIL timeout [%s]: got no ack expected ack by cycle %0d", cur_name, exp_lat);
            pending = 1'b0;
        end
        #1;
    endtask

    task automatic run(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
        start_op(nm, f, a, b, e, lat_m(f, a, b));
        wait_done();
    endtask

    task automatic directed(input string nm, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] lit);
        chk({nm, " model"}, ref_m(f, a, b), lit);
        run(nm, f, a, b, lit);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; rs1 = '0; rs2 = '0; f3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset res", res, 32'd0);
        chk("reset ack", {31'b0, ack}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

`ifdef RV32M_FAST_MUL_EN
        chk("lat MUL model", 32'(lat_m(3'd0, 32'd7, 32'hFFFF_FFFD)), 32'd1);
`else
        chk("lat MUL model", 32'(lat_m(3'd0, 32'd7, 32'hFFFF_FFFD)), 32'd34);
`endif
        chk("lat DIV model", 32'(lat_m(3'd4, 32'hFFFF_FFEC, 32'd6)), 32'd34);
        chk("lat DIV0 model", 32'(lat_m(3'd4, 32'd5, 32'd0)), 32'd2);
        chk("lat OVF model", 32'(lat_m(3'd6, MIN, 32'hFFFF_FFFF)), 32'd2);

        directed("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        repeat (5) @(posedge clk);
        #1;
        chk("mul hold", res, 32'hFFFF_FFEB);

        directed("MULH min*min", 3'd1, MIN, MIN, 32'h4000_0000);
        directed("MULHU -1*-1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        directed("MULHSU -1*-1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        directed("DIV -20/6", 3'd4, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD);
        directed("REM -20/6", 3'd6, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE);
        directed("DIVU 20/6", 3'd5, 32'd20, 32'd6, 32'd3);
        directed("REMU 20/6", 3'd7, 32'd20, 32'd6, 32'd2);
        directed("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        directed("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5);
        directed("DIV ovf", 3'd4, MIN, 32'hFFFF_FFFF, MIN);
        directed("REM ovf", 3'd6, MIN, 32'hFFFF_FFFF, 32'd0);

        // Start pulse in the ack cycle is dropped.
        start_op("DIV 5/0 en-in-ack", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        @(posedge clk); #1;
        en = 1'b1; rs1 = 32'd77; rs2 = 32'd3; f3 = 3'd5;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        wait_done();

        // Extra start pulses mid-operation are ignored.
        start_op("DIVU 100/7 extra-en", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        repeat (4) @(posedge clk);
        #1;
        en = 1'b1; rs1 = 32'd1000; rs2 = 32'd3; f3 = 3'd4;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        en = 1'b1; rs1 = 32'd55; rs2 = 32'd0; f3 = 3'd7;
        @(posedge clk); #1;
        en = 1'b0;
        wait_done();
        repeat (40) @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        start_op("MUL reset-abort", 3'd0, 32'd123, 32'd456, ref_m(3'd0, 32'd123, 32'd456),
                 lat_m(3'd0, 32'd123, 32'd456));
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        pending = 1'b0; hold_res = '0; cur_name = "reset-abort";
        #1;
        chk("abort res", res, 32'd0);
        chk("abort ack", {31'b0, ack}, 32'd0);
        chk("abort busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        directed("DIVU 9/2 after reset", 3'd5, 32'd9, 32'd2, 32'd4);

        // Randomized operations against the model.
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra;
            logic [31:0] rb;
            rf = 3'($urandom_range(0, 7));
            ra = rnd_opnd();
            rb = rnd_opnd();
            run($sformatf("rand%0d f3=%0d %h,%h", i, rf, ra, rb), rf, ra, rb, ref_m(rf, ra, rb));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
